// File: rtl/sram_pkg.sv
// sram_pkg: shared encodings and default widths for the SRAM emulator.
// Imported by the responder top and its RAM array.
package sram_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 8;
    localparam int MIN_ACTIVE_DEF = 1;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECTED = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        ERROR    = 3'd4
    } resp_state_t;

endpackage

// File: rtl/sram_array.sv
// sram_array: single-port RAM, synchronous write, registered read.
// Kept free of reset so it maps onto iCE40 block RAM.
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port and registered read port share the one address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: async-SRAM strobe target backed by on-chip RAM.
// Decodes /CE, /WE, /OE into reads and writes and flags protocol errors.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int MIN_ACTIVE = MIN_ACTIVE_DEF,
    parameter int CNT_WIDTH  = CNT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  CE,
    input  logic                  WE,
    input  logic                  OE,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataOE,
    input  logic                  ClearErr,
    output logic                  Error,
    output logic                  ErrorSticky,
    output logic [CNT_WIDTH-1:0]  AccessCount,
    output logic [2:0]            RespState
);

    localparam int WC_W = (MIN_ACTIVE < 1) ? 1 : $clog2(MIN_ACTIVE + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MIN_ACTIVE);

    resp_state_t state, state_nx;

    logic                  ce_q, we_q, oe_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic [WC_W-1:0]       we_cnt;

    logic ce_fall, we_rise, oe_rise;
    logic contention;
    logic end_write;
    logic addr_load;
    logic rd_issue;
    logic capture;
    logic commit;
    logic short_w;
    logic read_done;
    logic hold_read;
    logic err_nx;

    assign ce_fall = ce_q && !CE;
    assign we_rise = !we_q && WE;
    assign oe_rise = !oe_q && OE;

    // Next-state decode and per-cycle action strobes
    always_comb begin
        state_nx   = state;
        addr_load  = 1'b0;
        rd_issue   = 1'b0;
        commit     = 1'b0;
        short_w    = 1'b0;
        contention = !CE && !WE && !OE && (state != ERROR);
        end_write  = (state == WRITE) && (CE || we_rise);
        read_done  = (state == READ) && (CE || oe_rise);

        unique case (state)
            IDLE: begin
                if (ce_fall) begin
                    addr_load = 1'b1;
                    state_nx  = SELECTED;
                end
            end
            SELECTED: begin
                if (!OE) begin
                    state_nx = READ;
                    rd_issue = 1'b1;
                end else if (!WE) begin
                    state_nx = WRITE;
                end
            end
            READ: begin
                if (oe_rise) begin
                    state_nx = SELECTED;
                end
            end
            WRITE: begin
                if (we_rise) begin
                    state_nx = SELECTED;
                end
            end
            ERROR: begin
                state_nx = ERROR;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (end_write) begin
            if (we_cnt >= WC_MAX) begin
                commit = 1'b1;
            end else begin
                short_w = 1'b1;
            end
        end

        if (contention) begin
            state_nx = ERROR;
            rd_issue = 1'b0;
        end

        if (CE) begin
            state_nx = IDLE;
        end
    end

    assign capture   = (state_nx == WRITE);
    assign hold_read = (state == READ) && (state_nx == READ);
    assign err_nx    = contention || short_w;

    // FSM state, strobe history, latched address and write capture
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state   <= IDLE;
            ce_q    <= 1'b1;
            we_q    <= 1'b1;
            oe_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            we_cnt  <= '0;
        end else begin
            state <= state_nx;
            ce_q  <= CE;
            we_q  <= WE;
            oe_q  <= OE;
            if (addr_load) begin
                addr_q <= Addr;
            end
            if (capture) begin
                wdata_q <= DataIn;
                if (we_cnt < WC_MAX) begin
                    we_cnt <= we_cnt + WC_W'(1);
                end
            end else begin
                we_cnt <= '0;
            end
        end
    end

    // Registered outputs: read data path, error flags, access counter
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            DataOut     <= '0;
            DataOE      <= 1'b0;
            Error       <= 1'b0;
            ErrorSticky <= 1'b0;
            AccessCount <= '0;
        end else begin
            Error       <= err_nx;
            ErrorSticky <= err_nx | Error | (ErrorSticky & ~ClearErr);
            if (commit || read_done) begin
                AccessCount <= AccessCount + CNT_WIDTH'(1);
            end
            if (hold_read) begin
                DataOE  <= 1'b1;
                DataOut <= rdata;
            end else begin
                DataOE <= 1'b0;
            end
        end
    end

    assign RespState = state;

    sram_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk  (Clk),
        .wr_en(commit),
        .rd_en(rd_issue),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(rdata)
    );

endmodule
